// File: rtl/pid_controller_gen_if.sv
// ----------------------------------------------------------------------------
// pid_controller_gen_if
// Groups the sample handshake, run-time gains, synchronous clear and the
// controller result signals of pid_controller_gen.
//
// Modports:
//   master - sample/gain source: drives clear, in_valid, setpoint, feedback,
//            kp, ki, kd; observes in_ready, out_valid, out_data, busy, sat.
//   slave  - the controller: the mirror image of master.
//
// Parameters:
//   DW - width of setpoint, feedback and out_data
//   GW - width of kp, ki and kd
// ----------------------------------------------------------------------------
interface pid_controller_gen_if #(
    parameter int DW = 8,
    parameter int GW = 8
);
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] setpoint;
    logic [DW-1:0] feedback;
    logic [GW-1:0] kp;
    logic [GW-1:0] ki;
    logic [GW-1:0] kd;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          sat;

    modport master (
        output clear, in_valid, setpoint, feedback, kp, ki, kd,
        input  in_ready, out_valid, out_data, busy, sat
    );

    modport slave (
        input  clear, in_valid, setpoint, feedback, kp, ki, kd,
        output in_ready, out_valid, out_data, busy, sat
    );
endinterface

// File: rtl/pid_controller_gen.sv
// ----------------------------------------------------------------------------
// pid_controller_gen
// Sequential PID controller. One multiplier is time-shared across the P, I
// and D terms by a six-state FSM (IDLE, P, I, D, SUM, OUT), giving one
// result every six cycles. The integrator is clamped to +/-INT_MAX, the
// derivative term is suppressed on the first sample after reset/clear, and
// the output is floor-shifted by FRAC and range-clamped to [0, 2^DW-1].
//
// Optional feature (macro PID_SLEW_LIMIT_EN): when defined, each new output
// is additionally limited to within SLEW_MAX of the previous output.
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - pid_controller_gen_if.slave:
//           clear (sync clear), in_valid/in_ready (sample handshake),
//           setpoint/feedback (unsigned DW), kp/ki/kd (unsigned Q(GW-FRAC).FRAC),
//           out_valid (one-cycle pulse), out_data (unsigned DW, registered),
//           busy (FSM not idle), sat (last output range-clamped)
// ----------------------------------------------------------------------------
module pid_controller_gen #(
    parameter int DW       = 8,
    parameter int GW       = 8,
    parameter int FRAC     = 4,
    parameter int ACC_W    = 24,
    parameter int INT_MAX  = 65535,
    parameter int SLEW_MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pid_controller_gen_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P    = 3'd1;
    localparam logic [2:0] S_I    = 3'd2;
    localparam logic [2:0] S_D    = 3'd3;
    localparam logic [2:0] S_SUM  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    // Multiplier value operand: error difference needs one bit more than e.
    localparam int VW = DW + 2;
    // Product of a zero-extended gain and a VW-bit signed value.
    localparam int PW = GW + VW + 1;
    // Sum of three ACC_W terms cannot overflow in ACC_W+2 bits.
    localparam int SW = ACC_W + 2;

    localparam logic signed [ACC_W:0]  INT_HI  = (ACC_W+1)'(INT_MAX);
    localparam logic signed [ACC_W:0]  INT_LO  = -INT_HI;
    localparam logic signed [SW-1:0]   OUT_MAX = {{(SW-DW){1'b0}}, {DW{1'b1}}};

    logic [2:0]              state_r;
    logic [2:0]              state_nxt_s;
    logic signed [DW:0]      e_in_s;
    logic signed [DW:0]      e_r;
    logic signed [DW:0]      prev_e_r;
    logic                    first_r;
    logic [GW-1:0]           kp_r;
    logic [GW-1:0]           ki_r;
    logic [GW-1:0]           kd_r;
    logic [GW-1:0]           mul_gain_s;
    logic signed [VW-1:0]    e_ext_s;
    logic signed [VW-1:0]    de_s;
    logic signed [VW-1:0]    mul_val_s;
    logic signed [PW-1:0]    mul_a_s;
    logic signed [PW-1:0]    mul_b_s;
    logic signed [PW-1:0]    mul_prod_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] pterm_r;
    logic signed [ACC_W-1:0] integ_r;
    logic signed [ACC_W-1:0] dterm_r;
    logic signed [ACC_W:0]   integ_sum_s;
    logic signed [ACC_W-1:0] integ_next_s;
    logic signed [SW-1:0]    acc_s;
    logic signed [SW-1:0]    y_s;
    logic [DW-1:0]           range_s;
    logic                    range_sat_s;
    logic [DW-1:0]           result_s;
    logic [DW-1:0]           out_data_r;
    logic                    out_valid_r;
    logic                    sat_r;
    logic                    busy_r;
    logic                    in_ready_r;

    assign e_in_s  = $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.feedback});
    assign e_ext_s = {e_r[DW], e_r};
    assign de_s    = e_ext_s - {prev_e_r[DW], prev_e_r};

    // Next-state logic: fixed walk through the terms once a sample is taken.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = S_P;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_P:     state_nxt_s = S_I;
            S_I:     state_nxt_s = S_D;
            S_D:     state_nxt_s = S_SUM;
            S_SUM:   state_nxt_s = S_OUT;
            S_OUT:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Shared multiplier operand select: the state decides which gain/value pair.
    always_comb begin
        mul_gain_s = '0;
        mul_val_s  = '0;
        case (state_r)
            S_P: begin
                mul_gain_s = kp_r;
                mul_val_s  = e_ext_s;
            end
            S_I: begin
                mul_gain_s = ki_r;
                mul_val_s  = e_ext_s;
            end
            S_D: begin
                mul_gain_s = kd_r;
                mul_val_s  = de_s;
            end
            default: begin
                mul_gain_s = '0;
                mul_val_s  = '0;
            end
        endcase
    end

    assign mul_a_s    = $signed({{(PW-GW){1'b0}}, mul_gain_s});
    assign mul_b_s    = {{(PW-VW){mul_val_s[VW-1]}}, mul_val_s};
    assign mul_prod_s = mul_a_s * mul_b_s;
    assign prod_s     = {{(ACC_W-PW){mul_prod_s[PW-1]}}, mul_prod_s};

    assign integ_sum_s = {integ_r[ACC_W-1], integ_r} + {prod_s[ACC_W-1], prod_s};

    // Anti-windup: saturate the integrator instead of letting it grow.
    always_comb begin
        if (integ_sum_s > INT_HI) begin
            integ_next_s = INT_HI[ACC_W-1:0];
        end else if (integ_sum_s < INT_LO) begin
            integ_next_s = INT_LO[ACC_W-1:0];
        end else begin
            integ_next_s = integ_sum_s[ACC_W-1:0];
        end
    end

    assign acc_s = {{2{pterm_r[ACC_W-1]}}, pterm_r}
                 + {{2{integ_r[ACC_W-1]}}, integ_r}
                 + {{2{dterm_r[ACC_W-1]}}, dterm_r};
    // Arithmetic shift rounds toward minus infinity, as intended.
    assign y_s = acc_s >>> FRAC;

    // Range clamp of the scaled sum into the unsigned output range.
    always_comb begin
        if (y_s[SW-1]) begin
            range_s     = '0;
            range_sat_s = 1'b1;
        end else if (y_s > OUT_MAX) begin
            range_s     = '1;
            range_sat_s = 1'b1;
        end else begin
            range_s     = y_s[DW-1:0];
            range_sat_s = 1'b0;
        end
    end

`ifdef PID_SLEW_LIMIT_EN
    localparam logic [DW-1:0] SLEW_V = DW'(SLEW_MAX);

    logic [DW:0]   slew_hi_w_s;
    logic [DW-1:0] slew_hi_s;
    logic [DW-1:0] slew_lo_s;

    // Slew window around the previous output, bounded to the output range.
    always_comb begin
        slew_hi_w_s = {1'b0, out_data_r} + {1'b0, SLEW_V};
        if (slew_hi_w_s[DW]) begin
            slew_hi_s = '1;
        end else begin
            slew_hi_s = slew_hi_w_s[DW-1:0];
        end
        if (out_data_r > SLEW_V) begin
            slew_lo_s = out_data_r - SLEW_V;
        end else begin
            slew_lo_s = '0;
        end
        if (range_s > slew_hi_s) begin
            result_s = slew_hi_s;
        end else if (range_s < slew_lo_s) begin
            result_s = slew_lo_s;
        end else begin
            result_s = range_s;
        end
    end
`else
    // Without slew limiting the range-clamped value goes straight out.
    always_comb begin
        result_s = range_s;
    end
`endif

    // FSM state plus registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (bus.clear) begin
            state_r    <= S_IDLE;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            in_ready_r <= (state_nxt_s == S_IDLE);
        end
    end

    // Datapath: capture on accept, one term per state, outputs on SUM->OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r         <= '0;
            prev_e_r    <= '0;
            first_r     <= 1'b1;
            kp_r        <= '0;
            ki_r        <= '0;
            kd_r        <= '0;
            pterm_r     <= '0;
            integ_r     <= '0;
            dterm_r     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else if (bus.clear) begin
            e_r         <= '0;
            prev_e_r    <= '0;
            first_r     <= 1'b1;
            pterm_r     <= '0;
            integ_r     <= '0;
            dterm_r     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        e_r  <= e_in_s;
                        kp_r <= bus.kp;
                        ki_r <= bus.ki;
                        kd_r <= bus.kd;
                    end
                end
                S_P: pterm_r <= prod_s;
                S_I: integ_r <= integ_next_s;
                S_D: begin
                    // No derivative kick on the first sample after reset/clear.
                    if (first_r) begin
                        dterm_r <= '0;
                    end else begin
                        dterm_r <= prod_s;
                    end
                end
                S_SUM: begin
                    // Registered here so out_valid is high during the OUT state.
                    out_data_r  <= result_s;
                    sat_r       <= range_sat_s;
                    out_valid_r <= 1'b1;
                end
                S_OUT: begin
                    prev_e_r <= e_r;
                    first_r  <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.sat       = sat_r;
endmodule

// File: tb/tb_pid_controller_gen.sv
// ----------------------------------------------------------------------------
// tb_pid_controller_gen
// Directed bench for pid_controller_gen. A cycle-level reference model tracks
// the controller (integer arithmetic, sample-by-sample) and is compared with
// the DUT on every falling edge; directed tests add literal expectations.
// ----------------------------------------------------------------------------
module tb_pid_controller_gen;
    localparam int DW       = 8;
    localparam int GW       = 8;
    localparam int FRAC     = 4;
    localparam int ACC_W    = 24;
    localparam int INT_MAX  = 480;
    localparam int SLEW_MAX = 16;
    localparam int OMAX     = 255;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pid_controller_gen_if #(.DW(DW), .GW(GW)) bus_if ();

    pid_controller_gen #(
        .DW(DW), .GW(GW), .FRAC(FRAC), .ACC_W(ACC_W),
        .INT_MAX(INT_MAX), .SLEW_MAX(SLEW_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_ph;
    int m_integ;
    int m_prev;
    int m_first;
    int m_out_data;
    int m_sat;
    int m_valid;
    int m_pend_data;
    int m_pend_sat;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_integ = 0; m_prev = 0; m_first = 1;
        m_out_data = 0; m_sat = 0; m_valid = 0;
        m_pend_data = 0; m_pend_sat = 0;
    endtask

    task automatic m_compute();
        int e, p, d, acc, y, r;
        e = int'(bus_if.setpoint) - int'(bus_if.feedback);
        p = int'(bus_if.kp) * e;
        m_integ = m_integ + int'(bus_if.ki) * e;
        if (m_integ > INT_MAX) m_integ = INT_MAX;
        if (m_integ < -INT_MAX) m_integ = -INT_MAX;
        d = (m_first != 0) ? 0 : int'(bus_if.kd) * (e - m_prev);
        m_prev  = e;
        m_first = 0;
        acc = p + m_integ + d;
        y = floor_div(acc, 1 << FRAC);
        r = (y < 0) ? 0 : ((y > OMAX) ? OMAX : y);
        m_pend_sat = (r != y) ? 1 : 0;
`ifdef PID_SLEW_LIMIT_EN
        if (r > m_out_data + SLEW_MAX) r = m_out_data + SLEW_MAX;
        if (r < m_out_data - SLEW_MAX) r = m_out_data - SLEW_MAX;
        if (r > OMAX) r = OMAX;
        if (r < 0) r = 0;
`endif
        m_pend_data = r;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || bus_if.clear) begin
                m_reset();
            end else begin
                m_valid = 0;
                if (m_ph == 0) begin
                    if (bus_if.in_valid) begin
                        m_compute();
                        m_ph = 1;
                    end
                end else if (m_ph == 4) begin
                    m_ph = 5;
                    m_valid = 1;
                    m_out_data = m_pend_data;
                    m_sat = m_pend_sat;
                end else if (m_ph == 5) begin
                    m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_out_valid", int'(bus_if.out_valid), m_valid);
            chk("m_out_data",  int'(bus_if.out_data),  m_out_data);
            chk("m_sat",       int'(bus_if.sat),       m_sat);
            chk("m_busy",      int'(bus_if.busy),      (m_ph != 0) ? 1 : 0);
            chk("m_in_ready",  int'(bus_if.in_ready),  (m_ph == 0) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers (start and end on a falling edge) ----
    task automatic do_clear();
        bus_if.clear = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
    endtask

    task automatic send(input int sp, input int fb, input int p, input int i, input int d);
        bus_if.setpoint = sp[DW-1:0];
        bus_if.feedback = fb[DW-1:0];
        bus_if.kp = p[GW-1:0];
        bus_if.ki = i[GW-1:0];
        bus_if.kd = d[GW-1:0];
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        // Gains and inputs change while busy; the result must not care.
        bus_if.kp = 8'hff; bus_if.ki = 8'hff; bus_if.kd = 8'hff;
        bus_if.setpoint = 8'h5a; bus_if.feedback = 8'hc3;
    endtask

    task automatic wait_out(input string name, input int exp_data, input int exp_sat);
        int n;
        n = 1;
        while (!bus_if.out_valid && n <= 20) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({name, "_latency"}, n, 5);
        chk({name, "_data"}, int'(bus_if.out_data), exp_data);
        chk({name, "_sat"}, int'(bus_if.sat), exp_sat);
        @(negedge clk);
    endtask

    int exp_int[5] = '{10, 20, 30, 30, 30};
`ifdef PID_SLEW_LIMIT_EN
    int exp_run[6] = '{16, 32, 48, 64, 80, 80};
    localparam int P_BASIC = 16;
    localparam int P_HIGH  = 16;
`else
    int exp_run[6] = '{80, 80, 80, 80, 80, 80};
    localparam int P_BASIC = 80;
    localparam int P_HIGH  = 255;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pulse_at[8];
        int pulse_dat[8];
        int np;
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        bus_if.clear = 1'b0; bus_if.in_valid = 1'b0;
        bus_if.setpoint = '0; bus_if.feedback = '0;
        bus_if.kp = '0; bus_if.ki = '0; bus_if.kd = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_data", int'(bus_if.out_data), 0);
        chk("rst_out_valid", int'(bus_if.out_valid), 0);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_sat", int'(bus_if.sat), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(bus_if.in_ready), 1);

        // Proportional only.
        do_clear();
        send(100, 60, 32, 0, 0);
        wait_out("p_basic", P_BASIC, 0);

        // Range clamps, low then high.
        send(10, 200, 16, 0, 0);
        wait_out("clamp_low", 0, 1);
        send(255, 0, 255, 0, 0);
        wait_out("clamp_high", P_HIGH, 1);

        // Integrator and anti-windup.
        do_clear();
        for (int k = 0; k < 5; k++) begin
            send(50, 40, 0, 16, 0);
            wait_out($sformatf("integ_%0d", k), exp_int[k], 0);
        end

        // Derivative without kick on the first sample.
        do_clear();
        send(80, 60, 0, 0, 16);
        wait_out("deriv_first", 0, 0);
        send(90, 60, 0, 0, 16);
        wait_out("deriv_second", 10, 0);

        // Clear during state I.
        do_clear();
        send(50, 40, 0, 16, 0);
        @(negedge clk);
        do_clear();
        chk("clr_busy", int'(bus_if.busy), 0);
        chk("clr_in_ready", int'(bus_if.in_ready), 1);
        for (int k = 0; k < 8; k++) begin
            chk("clr_no_valid", int'(bus_if.out_valid), 0);
            @(negedge clk);
        end
        send(50, 40, 0, 16, 0);
        wait_out("clr_integ_zeroed", 10, 0);

        // Fractional gain, floor rounding (1.5 * 7 = 10.5 -> 10).
        do_clear();
        send(7, 0, 24, 0, 0);
        wait_out("frac_floor", 10, 0);

        // Reset in the middle of a computation.
        send(100, 60, 32, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_data", int'(bus_if.out_data), 0);
        chk("midrst_busy", int'(bus_if.busy), 0);
        chk("midrst_in_ready", int'(bus_if.in_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("midrst_no_valid", int'(bus_if.out_valid), 0);
            @(negedge clk);
        end

        // Accept coincident with clear is dropped.
        bus_if.setpoint = 8'd100; bus_if.feedback = 8'd60; bus_if.kp = 8'd32;
        bus_if.ki = 8'd0; bus_if.kd = 8'd0;
        bus_if.in_valid = 1'b1;
        do_clear();
        bus_if.in_valid = 1'b0;
        chk("clr_accept_busy", int'(bus_if.busy), 0);
        for (int k = 0; k < 7; k++) begin
            chk("clr_accept_no_valid", int'(bus_if.out_valid), 0);
            @(negedge clk);
        end

        // in_valid held high: one sample every six cycles.
        do_clear();
        np = 0;
        bus_if.setpoint = 8'd100; bus_if.feedback = 8'd60;
        bus_if.kp = 8'd32; bus_if.ki = 8'd0; bus_if.kd = 8'd0;
        bus_if.in_valid = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (bus_if.out_valid && np < 8) begin
                pulse_at[np] = n;
                pulse_dat[np] = int'(bus_if.out_data);
                np = np + 1;
            end
        end
        bus_if.in_valid = 1'b0;
        chk("run_pulse_count", np, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < np) begin
                chk($sformatf("run_cycle_%0d", k), pulse_at[k], 5 + 6 * k);
                chk($sformatf("run_data_%0d", k), pulse_dat[k], exp_run[k]);
            end
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pid_controller_gen.md
Name: pid_controller_gen

Overview:
- Parametrised successor to the fixed 8-bit PID block. Provides configurable data and gain widths, fixed-point fractional gains and run-time gain ports.
- Adds a valid/ready input handshake, integral anti-windup clamp, derivative-kick suppression and a synchronous clear.
- Time-shares one multiplier across P, I and D via a sequential FSM.
- Sits between the setpoint/feedback sources and the actuator output pins of the tile.

Parameters:
- DW, 8, width of setpoint, feedback and out_data (unsigned).
- GW, 8, width of kp/ki/kd (unsigned fixed point).
- FRAC, 4, fractional bits in gains; output = accumulator >>> FRAC.
- ACC_W, 24, signed width of integrator and product registers.
- INT_MAX, 65535, integrator clamp magnitude; integrator is held in [-INT_MAX, +INT_MAX].
- SLEW_MAX, 16, maximum out_data change per sample (used only with PID_SLEW_LIMIT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of controller state
- in_valid  in  1  sample request
- in_ready  out  1  high when block can accept a sample
- setpoint  in  DW  desired value, unsigned
- feedback  in  DW  measured value, unsigned
- kp  in  GW  proportional gain, Q(GW-FRAC).FRAC
- ki  in  GW  integral gain, same format
- kd  in  GW  derivative gain, same format
- out_valid  out  1  one-cycle pulse, out_data updated
- out_data  out  DW  control output, unsigned, registered
- busy  out  1  high when FSM is not IDLE
- sat  out  1  last output range-clamped; registered, updated with out_valid

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; out_data=0, out_valid=0, sat=0, busy=0; integ=0, prev_e=0, first=1. in_ready=1 once out of reset (in_ready = state==IDLE).
- Accept on in_valid&&in_ready.
  - Capture e = setpoint - feedback as signed DW+1 bits.
  - Capture kp/ki/kd into registers; gain changes mid-computation have no effect.
- FSM, one state per cycle:
  - IDLE -> P (on accept); P: pterm = kp*e.
  - P -> I; I: integ = clamp(integ + ki*e, ±INT_MAX).
  - I -> D; D: dterm = first ? 0 : kd*(e - prev_e).
  - D -> SUM; SUM: acc = pterm + integ + dterm, computed in ACC_W+2 bits; no wrap.
  - SUM -> OUT; OUT: y = acc >>> FRAC (floor); out_data = clamp(y, 0, 2^DW-1); sat = (clamped); out_valid=1; prev_e=e; first=0.
  - OUT -> IDLE.
- Latency: accept at cycle 0 -> out_valid high in cycle 5. Throughput: 1 sample per 6 cycles with in_valid held high.
- Single multiplier: operands are zero-extended gain × signed (DW+2)-bit value; product sign-extended to ACC_W.
- in_valid while busy: ignored, not queued.
- clear (sync, priority over all else): FSM=IDLE, integ=0, prev_e=0, first=1, out_valid=0, sat=0, out_data=0. Any in-flight sample is discarded. An accept coincident with clear is dropped.
- Reset mid-operation: identical to the reset values above; no partial output.
- out_data holds its value between out_valid pulses.

Optional Feature:
- Macro PID_SLEW_LIMIT_EN.
- Defined: in OUT, the range-clamped y is further limited to out_data_prev ± SLEW_MAX, bounded to [0, 2^DW-1]. sat reflects the range clamp only.
- Undefined: no slew limit; SLEW_MAX is unused. Latency is unchanged in both cases.

Test Plan:
- kp=32, ki=kd=0, sp=100, fb=60 -> e=40, pterm=1280, out_valid 5 cycles after accept, out_data=80, sat=0.
- kp=16, sp=10, fb=200 -> y=-190 -> out_data=0, sat=1. Then kp=255, sp=255, fb=0 -> out_data=255, sat=1.
- INT_MAX=480, ki=16, kp=kd=0, sp=50, fb=40 repeated -> out_data 10, 20, 30, 30, 30 (anti-windup holds).
- kd=16, kp=ki=0: first sample e=20 -> out_data 0; second sample e=30 -> out_data 10.
- Integral test interrupted by clear during state I -> next cycle busy=0, in_ready=1, no out_valid. The next sample returns 10 (integrator zeroed).
- With PID_SLEW_LIMIT_EN and SLEW_MAX=16, kp=32, sp=100, fb=60 repeated from out_data=0 -> 16, 32, 48, 64, 80, 80. in_valid held high -> accepts exactly every 6 cycles.
